aes_mode_engine: RTL and testbench

// - Streaming AES-128 encryptor with selectable ECB, CBC and CTR modes, built around one aes_core instance.
// - Input and output are valid/ready streams, with a parametrised output buffer so the core keeps working under short output backpressure.
// - Key, mode and IV are loaded once per session; many blocks and messages then flow without reloading.

---
 rtl/aes_mode_engine.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_aes_mode_engine.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_engine.sv
// aes_mode_engine: streaming AES-128 encryptor (ECB/CBC/CTR) around one iterative aes_core,
// with a small registered output FIFO so the core keeps working under short backpressure.
module aes_mode_engine #(
  parameter int unsigned OUT_DEPTH = 2,
  parameter int unsigned CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [1:0]   cfg_mode,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  output logic         cfg_err,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy
);
  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);
  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_e;

  state_e           state_q;
  logic             cfg_valid_q, cfg_err_q, last_q;
  logic [1:0]       mode_q;
  logic [127:0]     key_q, iv_q, chain_q, pt_q, core_in_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [127:0]     mem_data_q [OUT_DEPTH];
  logic             mem_last_q [OUT_DEPTH];

  logic             core_start_c, core_done;
  logic [127:0]     core_ct;
  logic             in_hs_c, cfg_ok_c, push_c, pop_c;
  logic [127:0]     push_data_c, chain_next_c;

  assign in_ready     = (state_q == S_IDLE) && cfg_valid_q && !cfg_load && (count_q < CNT_W'(OUT_DEPTH));
  assign in_hs_c      = in_valid && in_ready;
  assign cfg_ok_c     = (state_q == S_IDLE) && (count_q == '0);
  assign core_start_c = (state_q == S_START);
  assign push_c       = (state_q == S_WAIT) && core_done;
  assign pop_c        = out_valid && out_ready;
  assign push_data_c  = (mode_q == MODE_CTR) ? (core_ct ^ pt_q) : core_ct;
  assign out_valid    = (count_q != '0);
  assign busy         = (state_q != S_IDLE) || (count_q != '0);
  assign cfg_err      = cfg_err_q;
  assign out_data     = mem_data_q[rd_ptr_q];
  assign out_last     = mem_last_q[rd_ptr_q];

  aes_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (core_start_c),
    .key   (key_q),
    .din   (core_in_q),
    .dout  (core_ct),
    .done  (core_done)
  );

  // Chaining value after a block completes: restart from IV on last, else per-mode update.
  always_comb begin
    chain_next_c = chain_q;
    if (last_q) begin
      chain_next_c = iv_q;
    end else if (mode_q == MODE_CBC) begin
      chain_next_c = core_ct;
    end else if (mode_q == MODE_CTR) begin
      chain_next_c = (chain_q & ~CTR_MASK) | ((chain_q + 128'd1) & CTR_MASK);
    end
  end

  // Block FSM plus configuration registers; one block in flight at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      mode_q      <= MODE_ECB;
      key_q       <= '0;
      iv_q        <= '0;
      chain_q     <= '0;
      pt_q        <= '0;
      core_in_q   <= '0;
      last_q      <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      if (cfg_load) begin
        if (cfg_ok_c) begin
          key_q       <= cfg_key;
          mode_q      <= cfg_mode;
          iv_q        <= cfg_iv;
          chain_q     <= cfg_iv;
          cfg_valid_q <= (cfg_mode != MODE_RSV);
          cfg_err_q   <= (cfg_mode == MODE_RSV);
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (in_hs_c) begin
            pt_q   <= in_data;
            last_q <= in_last;
            case (mode_q)
              MODE_CBC: core_in_q <= in_data ^ chain_q;
              MODE_CTR: core_in_q <= chain_q;
              default:  core_in_q <= in_data;
            endcase
            state_q <= S_START;
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            chain_q <= chain_next_c;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Output FIFO; a slot is always reserved at handshake, so push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        mem_data_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        mem_data_q[wr_ptr_q] <= push_data_c;
        mem_last_q[wr_ptr_q] <= last_q;
        wr_ptr_q             <= ptr_inc(wr_ptr_q);
      end
      if (pop_c) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push_c && !pop_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_c && pop_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// aes_core: iterative AES-128 encryption, one round per clock, round keys derived on the fly.
module aes_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic         done
);
  localparam int unsigned NR = 10;

  logic [127:0] state_q, rk_q, rk_next_c;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic         active_q, done_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box: multiplicative inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, b;
    sq = x;
    b  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 4; k++) sr[4*c+k] = sb[4*((c+k)%4)+k];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (!last) begin
        sr[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        sr[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        sr[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        sr[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sr[i];
    return r ^ rk;
  endfunction

  assign rk_next_c = next_key(rk_q, rcon_q);
  assign dout      = state_q;
  assign done      = done_q;

  // Initial AddRoundKey on start, then one full round per cycle; done pulses after round 10.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= '0;
      rk_q     <= '0;
      rcon_q   <= 8'h01;
      round_q  <= 4'd0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q  <= din ^ key;
        rk_q     <= key;
        rcon_q   <= 8'h01;
        round_q  <= 4'd1;
        active_q <= 1'b1;
      end else if (active_q) begin
        state_q <= enc_round(state_q, rk_next_c, round_q == 4'(NR));
        rk_q    <= rk_next_c;
        rcon_q  <= xtime(rcon_q);
        round_q <= round_q + 4'd1;
        if (round_q == 4'(NR)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_mode_engine.sv
// tb_aes_mode_engine: randomized scoreboard bench with a byte-level AES reference model.
module tb_aes_mode_engine;
  localparam logic [1:0] ECB = 2'b00;
  localparam logic [1:0] CBC = 2'b01;
  localparam logic [1:0] CTR = 2'b10;
  localparam logic [1:0] RSV = 2'b11;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_load;
  logic [1:0]   cfg_mode;
  logic [127:0] cfg_key, cfg_iv;
  logic         cfg_err;
  logic         in_valid, in_ready, in_last;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_last;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int sink_mode = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [7:0]   sbox_t [256];
  logic [1:0]   m_mode;
  logic [127:0] m_key, m_iv, m_chain;
  logic [127:0] bp_blk [3];

  aes_mode_engine #(.OUT_DEPTH(2), .CTR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
    .cfg_iv(cfg_iv), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      sbox_t[p] = x;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] blk);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, x, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127-8*i -: 8];
      s[i] = blk[127-8*i -: 8];
    end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        x      = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[x];
        rc     = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) s[4*c+k] = t[4*((c+k)%4)+k];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Message-level mode model: one call per accepted block, in acceptance order.
  task automatic model_block(input logic [127:0] pt, input logic last, output logic [127:0] ct);
    case (m_mode)
      CBC: begin
        ct      = aes_enc(m_key, pt ^ m_chain);
        m_chain = ct;
      end
      CTR: begin
        ct      = aes_enc(m_key, m_chain) ^ pt;
        m_chain = {m_chain[127:32], 32'(m_chain[31:0] + 32'd1)};
      end
      default: ct = aes_enc(m_key, pt);
    endcase
    if (last) m_chain = m_iv;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- sink and monitor ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (sink_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h with nothing expected", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_last", 128'(out_last), 128'(mon_e.last));
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic send(input logic [127:0] pt, input logic last, input logic use_want,
                      input logic [127:0] want);
    logic [127:0] ct;
    logic         acc;
    int           n;
    in_valid = 1'b1;
    in_data  = pt;
    in_last  = last;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 2000) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else begin
        n++;
        @(posedge clk);
        #1;
      end
    end
    if (acc) begin
      model_block(pt, last, ct);
      exp_q.push_back('{data: (use_want ? want : ct), last: last});
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [1:0] mode, input logic [127:0] key, input logic [127:0] iv,
                          input logic honoured, input logic with_valid);
    cfg_load = 1'b1;
    cfg_mode = mode;
    cfg_key  = key;
    cfg_iv   = iv;
    in_valid = with_valid;
    in_data  = rand128();
    in_last  = 1'b0;
    @(negedge clk);
    check("in_ready_during_load", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", 128'(cfg_err), 128'((!honoured || mode == RSV) ? 1 : 0));
    if (honoured) begin
      m_mode  = mode;
      m_key   = key;
      m_iv    = iv;
      m_chain = iv;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    check("cfg_err_clear", 128'(cfg_err), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 128'(exp_q.size() != 0 || busy), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic offer_blocks(input int cycles, inout int idx);
    logic [127:0] ct;
    for (int n = 0; n < cycles; n++) begin
      if (idx < 3) begin
        in_valid = 1'b1;
        in_data  = bp_blk[idx];
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        model_block(bp_blk[idx], 1'b0, ct);
        exp_q.push_back('{data: ct, last: 1'b0});
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k2, k, iv, p1, p2;
    int           n, idx, vcount;
    logic         found;

    rst = 1'b1; cfg_load = 1'b0; cfg_mode = ECB; cfg_key = '0; cfg_iv = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    m_mode = ECB; m_key = '0; m_iv = '0; m_chain = '0;
    build_sbox();
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cfg_err", 128'(cfg_err), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_data", out_data, 128'h0);
    @(posedge clk);
    #1;

    // ECB known answer plus done -> out_valid latency
    load_cfg(ECB, 128'h000102030405060708090a0b0c0d0e0f, '0, 1'b1, 1'b0);
    send(128'h00112233445566778899aabbccddeeff, 1'b0, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      if (dut.u_core.done) found = 1'b1;
      n++;
    end
    check("core_done_seen", 128'(found), 128'(1));
    check("out_valid_at_done", 128'(out_valid), 128'(0));
    @(negedge clk);
    check("out_valid_done_plus1", 128'(out_valid), 128'(1));
    check("in_ready_done_plus1", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    drain();

    // CBC known answers; the load also collides with in_valid and must win
    k2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    p1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    p2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    load_cfg(CBC, k2, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b1);
    send(p1, 1'b0, 1'b1, 128'h7649abac8119b246cee98e9b12e9197d);
    send(p2, 1'b0, 1'b1, 128'h5086cb9b507219ee95db113a917678b2);
    drain();

    // CTR known answers, then restart from IV after in_last
    load_cfg(CTR, k2, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 1'b1, 1'b0);
    send(p1, 1'b0, 1'b1, 128'h874d6191b620e3261bef6864990db6ce);
    send(p2, 1'b1, 1'b1, 128'h9806f66b7970fdff8617187bb9fffdff);
    send(p1, 1'b0, 1'b1, 128'h874d6191b620e3261bef6864990db6ce);
    drain();

    // CTR low-word wrap keeps the upper 96 bits
    k  = rand128();
    iv = {rand128() >> 32, 32'hffffffff};
    p1 = rand128();
    p2 = rand128();
    load_cfg(CTR, k, iv, 1'b1, 1'b0);
    send(p1, 1'b0, 1'b1, aes_enc(k, iv) ^ p1);
    send(p2, 1'b0, 1'b1, aes_enc(k, {iv[127:32], 32'h0}) ^ p2);
    drain();

    // Backpressure: two slots fill, third waits for one pop
    load_cfg(ECB, rand128(), '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) bp_blk[i] = rand128();
    sink_mode = 2;
    cycles(2);
    idx = 0;
    offer_blocks(40, idx);
    check("bp_accepted_two", 128'(idx), 128'(2));
    @(negedge clk);
    check("bp_in_ready_low", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    sink_mode = 0;
    cycles(1);
    sink_mode = 2;
    offer_blocks(40, idx);
    check("bp_accepted_three", 128'(idx), 128'(3));
    sink_mode = 0;
    drain();

    // cfg_load during WAIT is rejected and the old session continues
    k = rand128();
    load_cfg(ECB, k, '0, 1'b1, 1'b0);
    send(rand128(), 1'b0, 1'b0, '0);
    cycles(2);
    load_cfg(CBC, rand128(), rand128(), 1'b0, 1'b0);
    drain();
    send(rand128(), 1'b1, 1'b0, '0);
    drain();

    // Reserved mode: rejected with cfg_err and no acceptance
    load_cfg(RSV, rand128(), rand128(), 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = rand128();
    @(negedge clk);
    check("rsv_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    cycles(5);
    in_valid = 1'b0;
    check("rsv_no_output", 128'(busy), 128'(0));

    // Reset while a block is in WAIT abandons it
    load_cfg(ECB, rand128(), '0, 1'b1, 1'b0);
    send(rand128(), 1'b0, 1'b0, '0);
    cycles(3);
    rst = 1'b1;
    exp_q.delete();
    cycles(2);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    check("rst_wait_no_valid", 128'(vcount), 128'(0));
    check("rst_wait_busy", 128'(busy), 128'(0));
    check("rst_wait_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;

    // Randomized sessions with random backpressure
    sink_mode = 1;
    for (int s = 0; s < 6; s++) begin
      iv = rand128();
      if (s % 2 == 1) iv[31:0] = 32'hfffffffe;
      load_cfg(2'($urandom_range(0, 2)), rand128(), iv, 1'b1, 1'b0);
      for (int b = 0; b < 12; b++) send(rand128(), ($urandom_range(0, 3) == 0), 1'b0, '0);
      drain();
    end
    sink_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
